// File: rtl/greenhouse_pkg.sv
// Shared types and constants for the greenhouse temperature display path.
package greenhouse_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned DEF_MAX_VALUE = 999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } conv_state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] hundreds;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd3_t;

  // BCD digits needed for 2**w-1 (w*log10(2) rounded down, plus one); at least
  // four so a thousands digit always exists to flag out-of-range samples.
  function automatic int unsigned bcd_digits(input int unsigned w);
    int unsigned d;
    d = (w * 30103) / 100000 + 1;
    return (d < 4) ? 4 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_dabble_step
  import greenhouse_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= DIGIT_W'(5)) adj_c = digit + DIGIT_W'(3);
  end

endmodule

// File: rtl/temp_bcd_converter.sv
// Binary temperature to three BCD digits, committed to the display on frame_start.
// Optional TEMP_BCD_SATURATE_EN: out-of-range samples display 9,9,9 instead of value mod 1000.
module temp_bcd_converter
  import greenhouse_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned MAX_VALUE = DEF_MAX_VALUE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sample_value,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic               frame_start,
  output logic [DIGIT_W-1:0] temp_value_100,
  output logic [DIGIT_W-1:0] temp_value_10,
  output logic [DIGIT_W-1:0] temp_value_1,
  output logic               overflow,
  output logic               update
);

  localparam int unsigned NDIG  = bcd_digits(WIDTH);
  localparam int unsigned BCD_W = NDIG * DIGIT_W;
  localparam int unsigned LOW_W = 3 * DIGIT_W;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned CMP_W = (WIDTH > 32) ? WIDTH : 32;
  localparam int unsigned SH_W  = BCD_W + WIDTH;

  conv_state_t       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              gt_max_q;
  bcd3_t             res_q;
  logic              res_ovf_q;
  bcd3_t             disp_q;

  logic [BCD_W-1:0]  bcd_adj_c;
  logic [SH_W-1:0]   shift_c;
  bcd3_t             low_c;
  bcd3_t             res_next_c;
  logic              ovf_c;

  // Add-3 correction on every digit ahead of each shift.
  for (genvar g = 0; g < NDIG; g++) begin : g_dabble
    bcd_dabble_step u_step (
      .digit (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .adj_c (bcd_adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shift_c = {bcd_adj_c, bin_q} << 1;
  assign low_c   = bcd3_t'(bcd_q[LOW_W-1:0]);
  // Thousands and above only feed the overflow status, never the display.
  assign ovf_c   = gt_max_q | (|bcd_q[BCD_W-1:LOW_W]);

`ifdef TEMP_BCD_SATURATE_EN
  assign res_next_c = ovf_c ? bcd3_t'({DIGIT_W'(9), DIGIT_W'(9), DIGIT_W'(9)}) : low_c;
`else
  assign res_next_c = low_c;
`endif

  // Conversion FSM: accept in IDLE, WIDTH shift steps plus one finalize cycle, commit in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      gt_max_q     <= 1'b0;
      res_q        <= '0;
      res_ovf_q    <= 1'b0;
      disp_q       <= '0;
      overflow     <= 1'b0;
      update       <= 1'b0;
      sample_ready <= 1'b1;
    end else begin
      update <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            bin_q        <= sample_value;
            bcd_q        <= '0;
            cnt_q        <= '0;
            gt_max_q     <= CMP_W'(sample_value) > CMP_W'(MAX_VALUE);
            sample_ready <= 1'b0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            res_q     <= res_next_c;
            res_ovf_q <= ovf_c;
            state_q   <= HOLD;
          end else begin
            bcd_q <= shift_c[SH_W-1:WIDTH];
            bin_q <= shift_c[WIDTH-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (frame_start) begin
            disp_q       <= res_q;
            overflow     <= res_ovf_q;
            update       <= 1'b1;
            sample_ready <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          sample_ready <= 1'b1;
        end
      endcase
    end
  end

  assign temp_value_100 = disp_q.hundreds;
  assign temp_value_10  = disp_q.tens;
  assign temp_value_1   = disp_q.ones;

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Directed bench for temp_bcd_converter (WIDTH=10, MAX_VALUE=999).
module tb_temp_bcd_converter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sample_value;
  logic       sample_valid;
  logic       sample_ready;
  logic       frame_start;
  logic [3:0] temp_value_100, temp_value_10, temp_value_1;
  logic       overflow;
  logic       update;

  int n_cmp = 0;
  int n_err = 0;

  temp_bcd_converter #(.WIDTH(10), .MAX_VALUE(999)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_value   (sample_value),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .frame_start    (frame_start),
    .temp_value_100 (temp_value_100),
    .temp_value_10  (temp_value_10),
    .temp_value_1   (temp_value_1),
    .overflow       (overflow),
    .update         (update)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int h, input int t, input int o);
    check({tag, ".100"}, 16'(temp_value_100), 16'(h));
    check({tag, ".10"},  16'(temp_value_10),  16'(t));
    check({tag, ".1"},   16'(temp_value_1),   16'(o));
  endtask

  // Accept a sample at the next edge, then run up to the edge that enters HOLD.
  task automatic convert(input logic [9:0] v);
    sample_valid = 1'b1;
    sample_value = v;
    tick();
    sample_valid = 1'b0;
    check("ready_low_after_accept", 16'(sample_ready), 16'd0);
    tick(11);
  endtask

  task automatic commit_now;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_value = 10'd725;
    sample_valid = 1'b1;
    frame_start  = 1'b0;

    // Reset state
    tick(3);
    check_disp("reset", 0, 0, 0);
    check("reset.overflow", 16'(overflow), 16'd0);
    check("reset.update", 16'(update), 16'd0);
    check("reset.ready", 16'(sample_ready), 16'd1);

    // 725 accepted on the first edge after release, committed 30 edges later
    rst_n = 1'b1;
    tick();
    check("t1.ready_accept", 16'(sample_ready), 16'd0);
    sample_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("t1.ready_busy", 16'(sample_ready), 16'd0);
    end
    tick(18);
    check_disp("t1.before_commit", 0, 0, 0);
    check("t1.no_update_yet", 16'(update), 16'd0);
    commit_now();
    check_disp("t1.commit", 7, 2, 5);
    check("t1.update", 16'(update), 16'd1);
    check("t1.overflow", 16'(overflow), 16'd0);
    check("t1.ready_back", 16'(sample_ready), 16'd1);
    tick();
    check("t1.update_one_cycle", 16'(update), 16'd0);
    check_disp("t1.stable", 7, 2, 5);

    // 0 after 725; display stays put during conversion
    sample_valid = 1'b1;
    sample_value = 10'd0;
    tick();
    sample_valid = 1'b0;
    tick(5);
    check_disp("t2.mid_shift", 7, 2, 5);
    tick(6);
    commit_now();
    check_disp("t2.commit", 0, 0, 0);
    check("t2.update", 16'(update), 16'd1);
    check("t2.overflow", 16'(overflow), 16'd0);

    // 1023: above MAX_VALUE
    convert(10'd1023);
    commit_now();
`ifdef TEMP_BCD_SATURATE_EN
    check_disp("t3.commit", 9, 9, 9);
`else
    check_disp("t3.commit", 0, 2, 3);
`endif
    check("t3.overflow", 16'(overflow), 16'd1);
    check("t3.update", 16'(update), 16'd1);

    // 999: largest in-range value; overflow holds until the commit clears it
    convert(10'd999);
    check("t3b.overflow_held", 16'(overflow), 16'd1);
    commit_now();
    check_disp("t3b.commit", 9, 9, 9);
    check("t3b.overflow_clear", 16'(overflow), 16'd0);

    // 1000: first out-of-range value
    convert(10'd1000);
    commit_now();
`ifdef TEMP_BCD_SATURATE_EN
    check_disp("t3c.commit", 9, 9, 9);
`else
    check_disp("t3c.commit", 0, 0, 0);
`endif
    check("t3c.overflow", 16'(overflow), 16'd1);

    // sample_valid held through SHIFT with changing values: only 314 shown
    sample_valid = 1'b1;
    sample_value = 10'd314;
    tick();
    for (int i = 1; i <= 11; i++) begin
      sample_value = 10'(100 + i * 37);
      check("t4.ready_busy", 16'(sample_ready), 16'd0);
      tick();
    end
    sample_valid = 1'b0;
    commit_now();
    check_disp("t4.commit", 3, 1, 4);
    check("t4.overflow", 16'(overflow), 16'd0);
    check("t4.ready_back", 16'(sample_ready), 16'd1);
    tick();

    // frame_start on the edge that enters HOLD must not commit
    sample_valid = 1'b1;
    sample_value = 10'd468;
    tick();
    sample_valid = 1'b0;
    tick(10);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t5.no_early_update", 16'(update), 16'd0);
    check_disp("t5.no_early_commit", 3, 1, 4);
    tick(4);
    check("t5.still_waiting", 16'(update), 16'd0);
    commit_now();
    check_disp("t5.commit", 4, 6, 8);
    check("t5.update", 16'(update), 16'd1);

    // Reset during SHIFT of 512 aborts the conversion
    sample_valid = 1'b1;
    sample_value = 10'd512;
    tick();
    sample_valid = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_disp("t6.in_reset", 0, 0, 0);
    check("t6.overflow", 16'(overflow), 16'd0);
    check("t6.ready_in_reset", 16'(sample_ready), 16'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6.ready_after", 16'(sample_ready), 16'd1);
    for (int i = 0; i < 20; i++) begin
      frame_start = (i % 4 == 0);
      tick();
      check("t6.no_update", 16'(update), 16'd0);
    end
    frame_start = 1'b0;
    check_disp("t6.after_release", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
